// File: rtl/hps_rst_pkg.sv
// Shared types and default timing constants for the HPS reset request sequencer.
package hps_rst_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_RST = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    COLD  = 2'd1,
    WARM  = 2'd2,
    DEBUG = 2'd3
  } req_t;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_PULSE_CYCLES    = 64;
  localparam int DEF_WAIT_CYCLES     = 65535;
  localparam int DEF_HOLDOFF_CYCLES  = 1024;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/hps_rst_debounce.sv
// Two-flop synchroniser plus debounce counter for one active-low button;
// emits a single-cycle press event on a debounced 1->0 transition.
module hps_rst_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= raw_n;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Only an unbroken run of differing samples moves the debounced level.
      if (sync_p1 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
          press <= ~sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hps_reset_req_ctrl.sv
// HPS reset request sequencer: debounce, arbitrate, pulse, track h2f_reset_n, hold off.
// Optional macro HPS_RST_STM_EN adds the stm_hwevents trace output.
module hps_reset_req_ctrl
  import hps_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int WAIT_CYCLES     = DEF_WAIT_CYCLES,
  parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       cold_btn_n,
  input  logic       warm_btn_n,
  input  logic       debug_btn_n,
  input  logic       h2f_reset_n,
  output logic       f2h_cold_reset_req_n,
  output logic       f2h_warm_reset_req_n,
  output logic       f2h_debug_reset_req_n,
  output logic       busy,
  output logic [1:0] last_req,
  output logic       timeout
`ifdef HPS_RST_STM_EN
  ,
  output logic [27:0] stm_hwevents
`endif
);

  logic             cold_press, warm_press, debug_press;
  logic             h2f_p0, h2f_p1;
  state_t           state, next_state;
  req_t             arb, req_type, last_q, last_d;
  logic [CNT_W-1:0] cnt;
  logic             seen_low;
  logic             accept, pulse_done, wait_done, wait_expire, hold_done;
  logic             cold_d, warm_d, debug_d, busy_d, timeout_d;

  hps_rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_cold (
    .clk(clk_clk), .rst_n(reset_reset_n), .raw_n(cold_btn_n), .press(cold_press)
  );
  hps_rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_warm (
    .clk(clk_clk), .rst_n(reset_reset_n), .raw_n(warm_btn_n), .press(warm_press)
  );
  hps_rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_debug (
    .clk(clk_clk), .rst_n(reset_reset_n), .raw_n(debug_btn_n), .press(debug_press)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      h2f_p0 <= 1'b1;
      h2f_p1 <= 1'b1;
    end else begin
      h2f_p0 <= h2f_reset_n;
      h2f_p1 <= h2f_p0;
    end
  end

  // Fixed priority; losers are simply dropped.
  always_comb begin
    arb = NONE;
    if (cold_press)       arb = COLD;
    else if (warm_press)  arb = WARM;
    else if (debug_press) arb = DEBUG;
  end

  assign accept      = (state == IDLE) && (arb != NONE) && h2f_p1;
  assign pulse_done  = (state == ASSERT) && (cnt == CNT_W'(PULSE_CYCLES - 1));
  assign wait_done   = (state == WAIT_RST) && seen_low && h2f_p1;
  assign wait_expire = (state == WAIT_RST) && !wait_done && (cnt == CNT_W'(WAIT_CYCLES - 1));
  assign hold_done   = (state == HOLDOFF) && (cnt == CNT_W'(HOLDOFF_CYCLES - 1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      seen_low <= 1'b0;
    end else begin
      state <= next_state;
      if ((state != next_state) || (state == IDLE)) cnt <= '0;
      else                                          cnt <= cnt + 1'b1;
      if (state != WAIT_RST) seen_low <= 1'b0;
      else if (!h2f_p1)      seen_low <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = ASSERT;
      ASSERT:   if (pulse_done) next_state = (last_q == DEBUG) ? HOLDOFF : WAIT_RST;
      WAIT_RST: if (wait_done || wait_expire) next_state = HOLDOFF;
      HOLDOFF:  if (hold_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs are decoded from next_state.
  always_comb begin
    req_type  = accept ? arb : last_q;
    cold_d    = 1'b1;
    warm_d    = 1'b1;
    debug_d   = 1'b1;
    if (next_state == ASSERT) begin
      case (req_type)
        COLD:    cold_d  = 1'b0;
        WARM:    warm_d  = 1'b0;
        DEBUG:   debug_d = 1'b0;
        default: ;
      endcase
    end
    busy_d    = (next_state != IDLE);
    last_d    = accept ? arb : last_q;
    timeout_d = accept ? 1'b0 : (timeout | wait_expire);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      f2h_cold_reset_req_n  <= 1'b1;
      f2h_warm_reset_req_n  <= 1'b1;
      f2h_debug_reset_req_n <= 1'b1;
      busy                  <= 1'b0;
      last_q                <= NONE;
      timeout               <= 1'b0;
    end else begin
      f2h_cold_reset_req_n  <= cold_d;
      f2h_warm_reset_req_n  <= warm_d;
      f2h_debug_reset_req_n <= debug_d;
      busy                  <= busy_d;
      last_q                <= last_d;
      timeout               <= timeout_d;
    end
  end

  assign last_req = last_q;

`ifdef HPS_RST_STM_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stm_hwevents <= '0;
    end else begin
      stm_hwevents <= {23'd0, wait_expire, wait_done,
                       accept && (arb == DEBUG),
                       accept && (arb == WARM),
                       accept && (arb == COLD)};
    end
  end
`endif

endmodule

// File: tb/tb_hps_reset_req_ctrl.sv
// Directed bench for hps_reset_req_ctrl with short debounce/pulse/wait/holdoff settings.
module tb_hps_reset_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cold_n, warm_n, debug_n, h2f_n;
  logic       cold_req, warm_req, debug_req, busy, timeout;
  logic [1:0] last_req;
`ifdef HPS_RST_STM_EN
  logic [27:0] stm;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  hps_reset_req_ctrl #(
    .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(8), .WAIT_CYCLES(100),
    .HOLDOFF_CYCLES(16), .CNT_W(16)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .cold_btn_n(cold_n),
    .warm_btn_n(warm_n),
    .debug_btn_n(debug_n),
    .h2f_reset_n(h2f_n),
    .f2h_cold_reset_req_n(cold_req),
    .f2h_warm_reset_req_n(warm_req),
    .f2h_debug_reset_req_n(debug_req),
    .busy(busy),
    .last_req(last_req),
    .timeout(timeout)
`ifdef HPS_RST_STM_EN
    ,
    .stm_hwevents(stm)
`endif
  );

  typedef struct {
    int         cyc;
    logic       warm_n;
    logic       h2f_n;
    logic       e_warm;
    logic       e_busy;
    logic [1:0] e_last;
    logic       e_to;
  } vec_t;

  vec_t vec[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0; cold_n = 1'b1; warm_n = 1'b1; debug_n = 1'b1; h2f_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    // Clean warm press followed by an HPS reset cycle.
    vec[0] = '{0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    vec[1] = '{6,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    vec[2] = '{7,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
    vec[3] = '{14, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
    vec[4] = '{15, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0};
    vec[5] = '{40, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
    vec[6] = '{60, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0};
    vec[7] = '{78, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0};
    vec[8] = '{79, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_to(vec[i].cyc);
      chk("warm_req", warm_req, vec[i].e_warm);
      chk("busy", busy, vec[i].e_busy);
      chk("last_req", last_req, vec[i].e_last);
      chk("timeout", timeout, vec[i].e_to);
      chk("cold_debug_idle", {cold_req, debug_req}, 2'b11);
      warm_n = vec[i].warm_n;
      h2f_n  = vec[i].h2f_n;
    end

    // Bounce rejection: 3 low / 1 high never forms a stable run.
    run_to(100);
    cyc = 0;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cold_n = 1'b0;
      repeat (3) begin tick(); if (!cold_req || !warm_req || !debug_req || busy) bad = 1'b1; end
      cold_n = 1'b1;
      tick(); if (!cold_req || !warm_req || !debug_req || busy) bad = 1'b1;
    end
    repeat (10) begin tick(); if (!cold_req || busy) bad = 1'b1; end
    chk("bounce_no_req", bad, 1'b0);

    // Simultaneous cold+debug, then timeout with h2f held high, press during HOLDOFF.
    cyc = 0;
    cold_n = 1'b0; debug_n = 1'b0;
    run_to(6);
    chk("sim_pre_cold", cold_req, 1'b1);
    run_to(7);
    chk("sim_last_req", last_req, 2'd1);
    bad = 1'b0;
    while (cyc < 15) begin
      if (cold_req || !debug_req || !warm_req) bad = 1'b1;
      tick();
    end
    chk("sim_only_cold_pulse", bad, 1'b0);
    chk("sim_cold_end", cold_req, 1'b1);
    chk("sim_debug_end", debug_req, 1'b1);
    cold_n = 1'b1; debug_n = 1'b1;
    run_to(110);
    warm_n = 1'b0;
    run_to(114);
    chk("to_before", timeout, 1'b0);
    run_to(115);
    chk("to_set", timeout, 1'b1);
    run_to(120);
    warm_n = 1'b1;
    run_to(130);
    chk("to_busy_holdoff", busy, 1'b1);
    run_to(131);
    chk("to_idle", busy, 1'b0);
    bad = 1'b0;
    while (cyc < 145) begin
      if (!warm_req || busy) bad = 1'b1;
      tick();
    end
    chk("holdoff_press_ignored", bad, 1'b0);
    chk("holdoff_last_req", last_req, 2'd1);
    chk("to_sticky", timeout, 1'b1);

    // Debug press clears timeout and skips WAIT_RST.
    cyc = 0;
    debug_n = 1'b0;
`ifdef HPS_RST_STM_EN
    run_to(6);
    chk("stm_dbg_pre", stm[2], 1'b0);
`endif
    run_to(7);
    chk("dbg_req_low", debug_req, 1'b0);
    chk("dbg_last_req", last_req, 2'd3);
    chk("dbg_to_cleared", timeout, 1'b0);
`ifdef HPS_RST_STM_EN
    chk("stm_dbg_pulse", stm, 28'h4);
    run_to(8);
    chk("stm_dbg_post", stm[2], 1'b0);
`endif
    run_to(14);
    chk("dbg_req_last_cycle", debug_req, 1'b0);
    run_to(15);
    chk("dbg_req_high", debug_req, 1'b1);
    debug_n = 1'b1;
    run_to(30);
    chk("dbg_busy_holdoff", busy, 1'b1);
    run_to(31);
    chk("dbg_idle", busy, 1'b0);

    // Press while h2f_reset_n is low in IDLE is masked.
    run_to(40);
    cyc = 0;
    h2f_n = 1'b0;
    run_to(3);
    cold_n = 1'b0;
    bad = 1'b0;
    while (cyc < 20) begin
      tick();
      if (!cold_req || busy) bad = 1'b1;
    end
    chk("h2f_low_masked", bad, 1'b0);
    cold_n = 1'b1;
    run_to(30);
    h2f_n = 1'b1;
    run_to(40);
    chk("h2f_low_busy", busy, 1'b0);
    chk("h2f_low_last_req", last_req, 2'd3);

    // Reset asserted in the 4th cycle of a warm pulse.
    cyc = 0;
    warm_n = 1'b0;
    run_to(10);
    chk("rst_mid_pulse_low", warm_req, 1'b0);
    rst_n = 1'b0;
    warm_n = 1'b1;
    #1;
    chk("rst_async_warm_req", warm_req, 1'b1);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_last_req", last_req, 2'd0);
    chk("rst_async_timeout", timeout, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_after_warm_req", warm_req, 1'b1);
    chk("rst_after_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
